data_mem_responder: RTL and testbench

//   Memory-side responder for the CPU data-memory port. It accepts word

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Word-addressed data-memory responder with a valid/ready request
//               port, configurable wait states and an illegal-address error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          src_write;
  logic [31:0]   src_addr;
  logic [31:0]   src_wdata;
  logic          src_legal;
  logic [AW-1:0] src_idx;
  logic          mem_we;

  assign req_ready  = (state_q == IDLE) & reset;
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  // With zero wait states the response is resolved on the accept edge itself,
  // so the transaction fields come straight from the request port in IDLE.
  always_comb begin
    src_write = write_q;
    src_addr  = addr_q;
    src_wdata = wdata_q;
    if (state_q == IDLE) begin
      src_write = req_write;
      src_addr  = req_addr;
      src_wdata = req_wdata;
    end
    src_legal = (src_addr[1:0] == 2'b00) && (src_addr[31:2] < 30'(DEPTH_WORDS));
    src_idx   = src_addr[AW+1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_resp) begin
      error_d = ~src_legal;
      rdata_d = (src_legal && !src_write) ? mem_q[src_idx] : 32'd0;
    end
  end

  assign mem_we = enter_resp & src_legal & src_write & reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[src_idx] <= src_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder (2 and 0 wait states)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int W0    = 2;
  localparam int W1    = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld [2];
  logic        wr  [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic        rdy [2];
  logic        rv  [2];
  logic        rerr[2];
  logic [31:0] rd  [2];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
    .clock(clk), .reset(rst_n),
    .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wr[0]),
    .req_addr(adr[0]), .req_wdata(wd[0]),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_error(rerr[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
    .clock(clk), .reset(rst_n),
    .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wr[1]),
    .req_addr(adr[1]), .req_wdata(wd[1]),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_error(rerr[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  function automatic int wcyc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  // Reference model: transactions are timed by absolute edge numbers.
  longint      ecnt = 0;
  longint      due  [2];
  longint      free [2];
  logic        pend [2];
  logic        p_wr [2];
  logic [31:0] p_adr[2];
  logic [31:0] p_wd [2];
  logic [31:0] mm   [2][DEPTH];
  logic        known[2][DEPTH];
  logic        e_valid[2];
  logic        e_err  [2];
  logic        e_known[2];
  logic [31:0] e_rdata[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      due[d] = 0; free[d] = 0; pend[d] = 0; p_wr[d] = 0; p_adr[d] = 0; p_wd[d] = 0;
      e_valid[d] = 0; e_err[d] = 0; e_known[d] = 1; e_rdata[d] = 0;
      for (int i = 0; i < DEPTH; i++) begin
        mm[d][i] = 0; known[d][i] = 0;
      end
    end
  end

  task automatic m_respond(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat);
    logic legal;
    int   idx;
    legal = (a[1:0] == 2'b00) && (a[31:2] < DEPTH);
    idx   = int'(a[9:2]);
    e_valid[d] = 1'b1;
    e_err[d]   = ~legal;
    e_known[d] = 1'b1;
    e_rdata[d] = 32'd0;
    if (legal) begin
      if (w) begin
        mm[d][idx]    = dat;
        known[d][idx] = 1'b1;
      end else begin
        e_rdata[d] = mm[d][idx];
        e_known[d] = known[d][idx];
      end
    end
  endtask

  function automatic logic e_ready(input int d);
    return rst_n && (ecnt >= free[d]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        pend[d] = 0; e_valid[d] = 0; e_err[d] = 0; e_rdata[d] = 0; e_known[d] = 1; free[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        e_valid[d] = 0;
        if (pend[d] && (ecnt + 1 == due[d])) begin
          m_respond(d, p_wr[d], p_adr[d], p_wd[d]);
          pend[d] = 0;
        end else if (vld[d] && (ecnt >= free[d])) begin
          free[d] = ecnt + 2 + wcyc(d);
          if (wcyc(d) == 0) begin
            m_respond(d, wr[d], adr[d], wd[d]);
          end else begin
            pend[d]  = 1;
            due[d]   = ecnt + 1 + wcyc(d);
            p_wr[d]  = wr[d];
            p_adr[d] = adr[d];
            p_wd[d]  = wd[d];
          end
        end
      end
      ecnt = ecnt + 1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("req_ready", d, 32'(rdy[d]), 32'(e_ready(d)));
      chk("resp_valid", d, 32'(rv[d]), 32'(e_valid[d]));
      if (e_valid[d]) begin
        chk("resp_error", d, 32'(rerr[d]), 32'(e_err[d]));
        if (e_known[d]) chk("resp_rdata", d, rd[d], e_rdata[d]);
      end
      if (!rst_n) begin
        chk("rst_rdata", d, rd[d], 32'd0);
        chk("rst_error", d, 32'(rerr[d]), 32'd0);
      end
    end
  end

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                     output logic [31:0] rdat, output logic err, output int lat);
    logic acc;
    rdat = 32'd0; err = 1'b0; lat = -1; acc = 1'b0;
    @(posedge clk); #2;
    vld[d] = 1'b1; wr[d] = w; adr[d] = a; wd[d] = dat;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (rdy[d]) acc = 1'b1;
    end
    chk("accepted", d, 32'(acc), 32'd1);
    if (!acc) begin
      vld[d] = 1'b0;
      return;
    end
    @(posedge clk); #2;
    vld[d] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rv[d]) begin
        rdat = rd[d]; err = rerr[d]; lat = i;
        break;
      end
    end
  endtask

  task automatic held(input int d, input int spacing);
    int acc_t[3];
    int k;
    int cyc;
    k = 0; cyc = 0;
    @(posedge clk); #2;
    vld[d] = 1'b1; wr[d] = 1'b0; adr[d] = 32'h10; wd[d] = 32'd0;
    while (k < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rdy[d]) begin
        acc_t[k] = cyc;
        k++;
      end
    end
    @(posedge clk); #2;
    vld[d] = 1'b0;
    chk("held_accepts", d, 32'(k), 32'd3);
    if (k == 3) begin
      chk("held_space1", d, 32'(acc_t[1] - acc_t[0]), 32'(spacing));
      chk("held_space2", d, 32'(acc_t[2] - acc_t[1]), 32'(spacing));
    end
    repeat (6) @(posedge clk);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0, 1:    a = 32'($urandom_range(0, 15)) << 2;
      2:       a = 32'($urandom_range(250, 255)) << 2;
      3:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      default: a = 32'h400 + ($urandom & 32'h0FFF_FFFC);
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] r;
    logic        e;
    int          l;
    logic        seen;
    int          rcnt;

    for (int d = 0; d < 2; d++) begin
      vld[d] = 0; wr[d] = 0; adr[d] = 0; wd[d] = 0;
    end

    // Reset held for three cycles, then released
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_ready_lit", d, 32'(rdy[d]), 32'd0);
        chk("rst_valid_lit", d, 32'(rv[d]), 32'd0);
        chk("rst_rdata_lit", d, rd[d], 32'd0);
      end
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("rel_ready_lit", d, 32'(rdy[d]), 32'd1);

    // Store then load with two wait states
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, r, e, l);
    chk("st10_err", 0, 32'(e), 32'd0);
    chk("st10_lat", 0, 32'(l), 32'd3);
    txn(0, 1'b0, 32'h10, 32'd0, r, e, l);
    chk("ld10_data", 0, r, 32'hDEADBEEF);
    chk("ld10_lat", 0, 32'(l), 32'd3);

    // Misaligned store is rejected and leaves memory alone
    txn(0, 1'b1, 32'h12, 32'hFFFFFFFF, r, e, l);
    chk("st12_err", 0, 32'(e), 32'd1);
    txn(0, 1'b0, 32'h10, 32'd0, r, e, l);
    chk("ld10b_data", 0, r, 32'hDEADBEEF);
    chk("ld10b_err", 0, 32'(e), 32'd0);

    // Out-of-range load and the last legal word
    txn(0, 1'b0, 32'h400, 32'd0, r, e, l);
    chk("ld400_err", 0, 32'(e), 32'd1);
    chk("ld400_data", 0, r, 32'd0);
    txn(0, 1'b1, 32'h3FC, 32'hCAFEF00D, r, e, l);
    chk("st3fc_err", 0, 32'(e), 32'd0);
    txn(0, 1'b0, 32'h3FC, 32'd0, r, e, l);
    chk("ld3fc_data", 0, r, 32'hCAFEF00D);
    chk("ld3fc_err", 0, 32'(e), 32'd0);

    // Reset during the wait states aborts the second store
    txn(0, 1'b1, 32'h20, 32'd0, r, e, l);
    chk("st20_err", 0, 32'(e), 32'd0);
    @(posedge clk); #2;
    vld[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h20; wd[0] = 32'h12345678;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy[0]) break;
    end
    @(posedge clk); #2;
    vld[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | rv[0];
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | rv[0];
    end
    chk("abort_no_resp", 0, 32'(seen), 32'd0);
    txn(0, 1'b0, 32'h20, 32'd0, r, e, l);
    chk("ld20_data", 0, r, 32'd0);
    chk("ld20_err", 0, 32'(e), 32'd0);

    // Zero wait states
    txn(1, 1'b1, 32'h3FC, 32'hA5A5_5A5A, r, e, l);
    chk("w0_st_lat", 1, 32'(l), 32'd1);
    chk("w0_st_err", 1, 32'(e), 32'd0);
    txn(1, 1'b0, 32'h3FC, 32'd0, r, e, l);
    chk("w0_ld_data", 1, r, 32'hA5A5_5A5A);
    chk("w0_ld_lat", 1, 32'(l), 32'd1);

    // Requests held valid back to back
    held(0, W0 + 2);
    held(1, W1 + 2);

    // Randomized traffic on both instances with occasional reset pulses
    rcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      for (int d = 0; d < 2; d++) begin
        vld[d] = 1'($urandom_range(0, 1));
        wr[d]  = 1'($urandom_range(0, 1));
        adr[d] = pick_addr();
        wd[d]  = $urandom;
      end
      if (!rst_n) begin
        rcnt--;
        if (rcnt <= 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        rcnt  = int'($urandom_range(1, 2));
      end
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) vld[d] = 1'b0;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
